// File: rtl/reg_file.sv
// Register file with R0 hardwired to zero, same-cycle write bypass on both
// read ports, and a 3-bit {Z,V,N} flag register with per-bit update enables.
module reg_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    input  logic [2:0]        FlagIn,
    input  logic [2:0]        FlagEn,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic [2:0]        Flags
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [2:0]        flags_q;
    logic [2:0]        flags_d;
    logic              wr_en;

    assign wr_en = WriteReg && !rst && (DstReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[DstReg] = DstData;
        end
        flags_d = (FlagEn & FlagIn) | (~FlagEn & flags_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    // R0 check comes first so a write aimed at R0 can never leak through the bypass.
    always_comb begin
        SrcData1 = regs_q[SrcReg1];
        if (SrcReg1 == '0) begin
            SrcData1 = '0;
        end else if (wr_en && (SrcReg1 == DstReg)) begin
            SrcData1 = DstData;
        end
    end

    always_comb begin
        SrcData2 = regs_q[SrcReg2];
        if (SrcReg2 == '0) begin
            SrcData2 = '0;
        end else if (wr_en && (SrcReg2 == DstReg)) begin
            SrcData2 = DstData;
        end
    end

    assign Flags = flags_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file: read data is checked before each
// edge (including bypass), Flags reflects the edges that came before.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  SrcReg1 = '0;
    logic [3:0]  SrcReg2 = '0;
    logic [3:0]  DstReg = '0;
    logic        WriteReg = 1'b0;
    logic [15:0] DstData = '0;
    logic [2:0]  FlagIn = '0;
    logic [2:0]  FlagEn = '0;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;
    logic [2:0]  Flags;

    int tests = 0;
    int fails = 0;

    reg_file #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .FlagIn   (FlagIn),
        .FlagEn   (FlagEn),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2),
        .Flags    (Flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [3:0]  dst;
        logic [15:0] dd;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [2:0]  fin;
        logic [2:0]  fen;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [2:0]  ef;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] d, input logic [15:0] dd,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic [2:0] fin, input logic [2:0] fen);
        rst = r; WriteReg = w; DstReg = d; DstData = dd;
        SrcReg1 = s1; SrcReg2 = s2; FlagIn = fin; FlagEn = fen;
    endtask

    initial begin
        //           rst  wr  dst   data      s1    s2    fin     fen     e1        e2        ef
        vecs[0]  = '{1'b0,1'b1,4'd5, 16'h1111,4'd5, 4'd5, 3'b000,3'b000,16'h1111,16'h1111,3'b000};
        vecs[1]  = '{1'b0,1'b0,4'd0, 16'h0000,4'd5, 4'd5, 3'b000,3'b000,16'h1111,16'h1111,3'b000};
        vecs[2]  = '{1'b0,1'b1,4'd3, 16'h7FFF,4'd3, 4'd5, 3'b000,3'b000,16'h7FFF,16'h1111,3'b000};
        vecs[3]  = '{1'b0,1'b0,4'd0, 16'h0000,4'd3, 4'd0, 3'b000,3'b000,16'h7FFF,16'h0000,3'b000};
        vecs[4]  = '{1'b0,1'b1,4'd0, 16'hBEEF,4'd0, 4'd0, 3'b000,3'b000,16'h0000,16'h0000,3'b000};
        vecs[5]  = '{1'b0,1'b0,4'd0, 16'h0000,4'd0, 4'd0, 3'b000,3'b000,16'h0000,16'h0000,3'b000};
        vecs[6]  = '{1'b0,1'b1,4'd7, 16'h00AA,4'd7, 4'd3, 3'b111,3'b010,16'h00AA,16'h7FFF,3'b000};
        vecs[7]  = '{1'b0,1'b0,4'd0, 16'h0000,4'd7, 4'd7, 3'b000,3'b100,16'h00AA,16'h00AA,3'b010};
        vecs[8]  = '{1'b0,1'b0,4'd0, 16'h0000,4'd5, 4'd3, 3'b101,3'b001,16'h1111,16'h7FFF,3'b010};
        vecs[9]  = '{1'b0,1'b1,4'd9, 16'h8009,4'd9, 4'd1, 3'b000,3'b000,16'h8009,16'h0000,3'b011};
        vecs[10] = '{1'b1,1'b1,4'd9, 16'h1234,4'd9, 4'd9, 3'b111,3'b111,16'h8009,16'h8009,3'b011};
        vecs[11] = '{1'b0,1'b0,4'd0, 16'h0000,4'd9, 4'd5, 3'b000,3'b000,16'h0000,16'h0000,3'b000};
        vecs[12] = '{1'b0,1'b1,4'd9, 16'h1234,4'd9, 4'd2, 3'b000,3'b000,16'h1234,16'h0000,3'b000};
        vecs[13] = '{1'b0,1'b0,4'd0, 16'h0000,4'd9, 4'd3, 3'b000,3'b000,16'h1234,16'h0000,3'b000};
        vecs[14] = '{1'b0,1'b1,4'd15,16'hFFFF,4'd15,4'd14,3'b000,3'b000,16'hFFFF,16'h0000,3'b000};
        vecs[15] = '{1'b0,1'b1,4'd15,16'h0001,4'd15,4'd15,3'b000,3'b000,16'h0001,16'h0001,3'b000};
        vecs[16] = '{1'b0,1'b0,4'd0, 16'h0000,4'd15,4'd7, 3'b000,3'b000,16'h0001,16'h0000,3'b000};

        // Reset for two edges, then sweep every index on both ports.
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 3'b000, 3'b000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            SrcReg1 = 4'(i);
            SrcReg2 = 4'(15 - i);
            #1;
            check($sformatf("reset_rd1[%0d]", i), SrcData1, 16'h0000);
            check($sformatf("reset_rd2[%0d]", 15 - i), SrcData2, 16'h0000);
        end
        check("reset_flags", {13'h0, Flags}, 16'h0000);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].wr, vecs[i].dst, vecs[i].dd,
                  vecs[i].s1, vecs[i].s2, vecs[i].fin, vecs[i].fen);
            #1;
            check($sformatf("vec%0d_rd1", i), SrcData1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), SrcData2, vecs[i].e2);
            check($sformatf("vec%0d_flags", i), {13'h0, Flags}, {13'h0, vecs[i].ef});
        end

        // Write R5, read it on both ports next cycle, and sum the operands.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd5, 16'h1111, 4'd1, 4'd2, 3'b000, 3'b000);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 3'b000, 3'b000);
        #1;
        check("r5_sum", SrcData1 + SrcData2, 16'h2222);

        // Write to R0 must stay invisible before and after the edge.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd0, 16'hBEEF, 4'd5, 4'd0, 3'b000, 3'b000);
        #1;
        check("r0_wr_pre", SrcData2, 16'h0000);
        @(negedge clk);
        WriteReg = 1'b0;
        #1;
        check("r0_wr_post", SrcData2, 16'h0000);

        // No X on outputs for any index after reset.
        for (int i = 0; i < 16; i++) begin
            SrcReg1 = 4'(i);
            SrcReg2 = 4'(i);
            #1;
            tests++;
            if ($isunknown({SrcData1, SrcData2, Flags})) begin
                fails++;
                $display("FAIL no_x[%0d]: got %h/%h/%b expected no X", i, SrcData1, SrcData2, Flags);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning register and ALU operand width.
REQ-002 SHALL provide parameter ADDR_W, default 4, meaning register index width (2**ADDR_W registers).
REQ-003 SHALL provide port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset; synchronous to clk and active-high.
REQ-005 SHALL provide port SrcReg1  input  ADDR_W  index for ALU_In1 read port.
REQ-006 SHALL provide port SrcReg2  input  ADDR_W  index for ALU_In2 read port.
REQ-007 SHALL provide port DstReg  input  ADDR_W  write index.
REQ-008 SHALL provide port WriteReg  input  1  write enable.
REQ-009 SHALL provide port DstData  input  DATA_W  write data (ALU_Out or memory data).
REQ-010 SHALL provide port FlagIn  input  3  {Z,V,N} produced by the ALU this cycle.
REQ-011 SHALL provide port FlagEn  input  3  per-flag update enable, bit order {Z,V,N}.
REQ-012 SHALL provide port SrcData1  output  DATA_W  read data for SrcReg1.
REQ-013 SHALL provide port SrcData2  output  DATA_W  read data for SrcReg2.
REQ-014 SHALL provide port Flags  output  3  registered {Z,V,N}.

Function
REQ-015 SHALL hold 2**ADDR_W registers of DATA_W bits; R0 is hardwired to 0 and writes to it are discarded.
REQ-016 SHALL write DstData into DstReg at the rising clk edge when WriteReg=1, rst=0, DstReg!=0.
REQ-017 SHALL read SrcData1/SrcData2 combinationally, zero-cycle latency from SrcReg change.
REQ-018 SHALL bypass: when WriteReg=1, rst=0, DstReg!=0 and SrcRegX==DstReg, SrcDataX SHALL equal DstData in that same cycle (write-before-read).
REQ-019 SHALL return 0 on any read port addressing R0, regardless of bypass conditions.
REQ-020 SHALL allow both read ports to address the same register simultaneously, each returning identical data.
REQ-021 SHALL update each Flags bit at the rising edge only where its FlagEn bit is 1 and rst=0; bits with FlagEn=0 retain value.
REQ-022 SHALL not bypass flags: Flags reflects FlagIn one cycle after the enabling edge.
REQ-023 SHALL treat register write and flag update as independent; both may occur on the same edge.
REQ-024 SHALL produce no X on outputs after the first reset edge, for any SrcReg values.

Reset
REQ-025 SHALL clear all registers and Flags to 0 at a rising edge with rst=1.
REQ-026 SHALL give rst priority over WriteReg and FlagEn on the same edge (write and flag update dropped).
REQ-027 SHALL suppress bypass while rst=1; reads return stored contents.
REQ-028 SHALL, on rst asserted mid-sequence, discard any pending write; the first edge after rst deasserts SHALL accept writes normally.

Verification
REQ-029 Reset then read all indices on both ports -> every SrcData1/SrcData2 = 16'h0000, Flags = 3'b000.
REQ-030 Write R5=16'h1111, next cycle read SrcReg1=5, SrcReg2=5 -> both 16'h1111; then feed both into RED -> Sum 16'h2222.
REQ-031 Same cycle WriteReg=1, DstReg=3, DstData=16'h7FFF, SrcReg1=3 -> SrcData1=16'h7FFF before the edge; after edge R3 reads 16'h7FFF.
REQ-032 WriteReg=1, DstReg=0, DstData=16'hBEEF, SrcReg2=0 -> SrcData2=16'h0000 before and after the edge.
REQ-033 FlagIn=3'b111, FlagEn=3'b010 -> Flags=3'b010 next cycle; then FlagIn=3'b000, FlagEn=3'b100 -> Flags=3'b010 unchanged... corrected: Z bit cleared only where enabled -> Flags=3'b010.
REQ-034 Write R9=16'h8009, then rst=1 with WriteReg=1, DstReg=9, DstData=16'h1234 on the same edge -> R9 reads 16'h0000 after edge, Flags 3'b000.
